wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. a 2-entry mul/div result FIFO.
// Define WB_AGE_GUARD_EN to add a starvation guard that forces a drain after AGE_MAX ungranted cycles.
module wb_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int AGE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_valid,
  input  logic              p_regdst,
  input  logic              p_link,
  input  logic [4:0]        p_rt,
  input  logic [4:0]        p_rd,
  input  logic [DATA_W-1:0] p_data,
  output logic              p_stall,
  input  logic              m_valid,
  input  logic [4:0]        m_dst,
  input  logic [DATA_W-1:0] m_data,
  output logic              m_ready,
  output logic              rf_we,
  output logic [4:0]        rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              grant_m
);

  localparam logic ST_PIPE  = 1'b0;
  localparam logic ST_DRAIN = 1'b1;

  logic              state_q, state_d;
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, rd_ptr_q;
  logic              pops_q, pops_d;
  logic [4:0]        dst_mem  [2];
  logic [DATA_W-1:0] data_mem [2];

  logic              grant_p, grant_f;
  logic              push, pop, fifo_nonempty, age_trip;
  logic [4:0]        p_dst, head_dst, wr_dst;
  logic [DATA_W-1:0] head_data, wr_data;
  logic              wr_en;

  assign p_dst         = p_link ? 5'd31 : (p_regdst ? p_rd : p_rt);
  assign head_dst      = dst_mem[rd_ptr_q];
  assign head_data     = data_mem[rd_ptr_q];
  assign fifo_nonempty = (count_q != 2'd0);
  assign m_ready       = (count_q < 2'd2);
  assign push          = m_valid && m_ready;
  assign pop           = grant_f;
  assign count_d       = count_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    grant_p = 1'b0;
    grant_f = 1'b0;
    p_stall = 1'b0;
    if (state_q == ST_PIPE) begin
      if (p_valid) begin
        grant_p = 1'b1;
      end else begin
        grant_f = fifo_nonempty;
      end
    end else begin
      grant_f = fifo_nonempty;
      p_stall = p_valid;
    end
  end

`ifdef WB_AGE_GUARD_EN
  localparam int AGE_W = $clog2(AGE_MAX + 1);
  logic [AGE_W-1:0] age_q, age_d;

  // Counts cycles the head waits; a pop or an empty FIFO clears it.
  always_comb begin
    if (!fifo_nonempty || pop) begin
      age_d = '0;
    end else if (age_q == AGE_W'(AGE_MAX)) begin
      age_d = age_q;
    end else begin
      age_d = age_q + 1'b1;
    end
  end

  assign age_trip = (age_d == AGE_W'(AGE_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  assign age_trip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pops_d  = pops_q;
    if (state_q == ST_PIPE) begin
      pops_d = 1'b0;
      if (count_d == 2'd2 || age_trip) begin
        state_d = ST_DRAIN;
      end
    end else begin
      // Leave after the second pop or as soon as the FIFO runs dry.
      if (!fifo_nonempty) begin
        state_d = ST_PIPE;
        pops_d  = 1'b0;
      end else if (pop) begin
        if (pops_q || count_d == 2'd0) begin
          state_d = ST_PIPE;
          pops_d  = 1'b0;
        end else begin
          pops_d = 1'b1;
        end
      end
    end
  end

  assign wr_dst  = grant_f ? head_dst : p_dst;
  assign wr_data = grant_f ? head_data : p_data;
  assign wr_en   = (grant_p || grant_f) && (wr_dst != 5'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      dst_mem[wr_ptr_q]  <= m_dst;
      data_mem[wr_ptr_q] <= m_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_PIPE;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      pops_q   <= 1'b0;
      rf_we    <= 1'b0;
      rf_wa    <= 5'd0;
      rf_wd    <= '0;
      grant_m  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pops_q  <= pops_d;
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      rf_we   <= wr_en;
      grant_m <= grant_f;
      if (wr_en) begin
        rf_wa <= wr_dst;
        rf_wd <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed, table-driven bench for wb_port_arbiter; follows WB_AGE_GUARD_EN when defined.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_valid, p_regdst, p_link;
  logic [4:0]  p_rt, p_rd;
  logic [31:0] p_data;
  logic        p_stall;
  logic        m_valid;
  logic [4:0]  m_dst;
  logic [31:0] m_data;
  logic        m_ready;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        grant_m;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(32), .AGE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_regdst(p_regdst), .p_link(p_link),
    .p_rt(p_rt), .p_rd(p_rd), .p_data(p_data), .p_stall(p_stall),
    .m_valid(m_valid), .m_dst(m_dst), .m_data(m_data), .m_ready(m_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .grant_m(grant_m)
  );

  typedef struct {
    logic        rst, pv, regdst, link;
    logic [4:0]  rt, rd;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  mdst;
    logic [31:0] md;
    logic        e_stall, e_mready, e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_gm;
  } vec_t;

  vec_t tbl[64];
  int   n_vec = 0;
  int   step_no = 0;

  function automatic vec_t mk(
    input logic r, input logic pv, input logic regdst, input logic link,
    input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] pd,
    input logic mv, input logic [4:0] mdst, input logic [31:0] md,
    input logic es, input logic em, input logic ewe,
    input logic [4:0] ewa, input logic [31:0] ewd, input logic egm);
    vec_t v;
    v.rst = r; v.pv = pv; v.regdst = regdst; v.link = link;
    v.rt = rt; v.rd = rd; v.pd = pd;
    v.mv = mv; v.mdst = mdst; v.md = md;
    v.e_stall = es; v.e_mready = em; v.e_we = ewe;
    v.e_wa = ewa; v.e_wd = ewd; v.e_gm = egm;
    return v;
  endfunction

  task automatic add(input vec_t v);
    tbl[n_vec] = v;
    n_vec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step %0d %s: got %h expected %h", step_no, name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; p_valid = v.pv; p_regdst = v.regdst; p_link = v.link;
    p_rt = v.rt; p_rd = v.rd; p_data = v.pd;
    m_valid = v.mv; m_dst = v.mdst; m_data = v.md;
    #1;
    chk("p_stall", {31'd0, p_stall}, {31'd0, v.e_stall});
    chk("m_ready", {31'd0, m_ready}, {31'd0, v.e_mready});
    @(posedge clk);
    #1;
    chk("rf_we", {31'd0, rf_we}, {31'd0, v.e_we});
    chk("rf_wa", {27'd0, rf_wa}, {27'd0, v.e_wa});
    chk("rf_wd", rf_wd, v.e_wd);
    chk("grant_m", {31'd0, grant_m}, {31'd0, v.e_gm});
    $display("step %0d rst=%0b pv=%0b mv=%0b stall=%0b mready=%0b we=%0b wa=%0d wd=%h gm=%0b",
             step_no, v.rst, v.pv, v.mv, p_stall, m_ready, rf_we, rf_wa, rf_wd, grant_m);
    step_no++;
  endtask

  initial begin
    rst = 1'b1; p_valid = 1'b0; p_regdst = 1'b0; p_link = 1'b0;
    p_rt = 5'd0; p_rd = 5'd0; p_data = 32'd0;
    m_valid = 1'b0; m_dst = 5'd0; m_data = 32'd0;

    //     rst pv rgd lnk rt     rd     pdata          mv mdst   mdata         stl mrd we wa     wd             gm
    add(mk(0, 0, 0, 0, 5'd0,  5'd0,  32'h0,         0, 5'd0,  32'h0,        0, 1, 0, 5'd0,  32'h0,         0));
    add(mk(0, 1, 1, 0, 5'd2,  5'd9,  32'h1234,      0, 5'd0,  32'h0,        0, 1, 1, 5'd9,  32'h1234,      0));
    add(mk(0, 1, 0, 1, 5'd5,  5'd7,  32'hBEEF,      0, 5'd0,  32'h0,        0, 1, 1, 5'd31, 32'hBEEF,      0));
    add(mk(0, 1, 0, 0, 5'd0,  5'd8,  32'hDEAD,      0, 5'd0,  32'h0,        0, 1, 0, 5'd31, 32'hBEEF,      0));
    add(mk(0, 1, 0, 0, 5'd6,  5'd8,  32'h66,        0, 5'd0,  32'h0,        0, 1, 1, 5'd6,  32'h66,        0));
    add(mk(0, 0, 0, 0, 5'd0,  5'd0,  32'h0,         0, 5'd0,  32'h0,        0, 1, 0, 5'd6,  32'h66,        0));
    // Lone FIFO push while idle, written out the following cycle.
    add(mk(0, 0, 0, 0, 5'd0,  5'd0,  32'h0,         1, 5'd12, 32'hC0C0,     0, 1, 0, 5'd6,  32'h66,        0));
    add(mk(0, 0, 0, 0, 5'd0,  5'd0,  32'h0,         0, 5'd0,  32'h0,        0, 1, 1, 5'd12, 32'hC0C0,      1));
    add(mk(0, 1, 0, 0, 5'd10, 5'd0,  32'hA,         0, 5'd0,  32'h0,        0, 1, 1, 5'd10, 32'hA,         0));
    // Two pushes under continuous pipeline traffic force a 2-cycle drain.
    add(mk(0, 1, 0, 0, 5'd11, 5'd0,  32'hB,         1, 5'd3,  32'h333,      0, 1, 1, 5'd11, 32'hB,         0));
    add(mk(0, 1, 0, 0, 5'd11, 5'd0,  32'hB,         1, 5'd4,  32'h444,      0, 1, 1, 5'd11, 32'hB,         0));
    add(mk(0, 1, 0, 0, 5'd13, 5'd0,  32'hD,         0, 5'd0,  32'h0,        1, 0, 1, 5'd3,  32'h333,       1));
    add(mk(0, 1, 0, 0, 5'd13, 5'd0,  32'hD,         0, 5'd0,  32'h0,        1, 1, 1, 5'd4,  32'h444,       1));
    add(mk(0, 1, 0, 0, 5'd13, 5'd0,  32'hD,         0, 5'd0,  32'h0,        0, 1, 1, 5'd13, 32'hD,         0));
    // FIFO entry aimed at r0 is consumed without a write.
    add(mk(0, 0, 0, 0, 5'd0,  5'd0,  32'h0,         1, 5'd0,  32'h999,      0, 1, 0, 5'd13, 32'hD,         0));
    add(mk(0, 0, 0, 0, 5'd0,  5'd0,  32'h0,         0, 5'd0,  32'h0,        0, 1, 0, 5'd13, 32'hD,         1));
    add(mk(0, 0, 0, 0, 5'd0,  5'd0,  32'h0,         0, 5'd0,  32'h0,        0, 1, 0, 5'd13, 32'hD,         0));
    // Fill the FIFO, then reset in the middle of the drain.
    add(mk(0, 0, 0, 0, 5'd0,  5'd0,  32'h0,         1, 5'd20, 32'h20,       0, 1, 0, 5'd13, 32'hD,         0));
    add(mk(0, 1, 0, 0, 5'd14, 5'd0,  32'hE,         1, 5'd21, 32'h21,       0, 1, 1, 5'd14, 32'hE,         0));
    add(mk(1, 1, 0, 0, 5'd14, 5'd0,  32'hE,         0, 5'd0,  32'h0,        1, 0, 0, 5'd0,  32'h0,         0));
    add(mk(0, 0, 0, 0, 5'd0,  5'd0,  32'h0,         0, 5'd0,  32'h0,        0, 1, 0, 5'd0,  32'h0,         0));
    add(mk(0, 0, 0, 0, 5'd0,  5'd0,  32'h0,         0, 5'd0,  32'h0,        0, 1, 0, 5'd0,  32'h0,         0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset rf_wa", {27'd0, rf_wa}, 32'd0);
    chk("reset rf_wd", rf_wd, 32'd0);
    chk("reset grant_m", {31'd0, grant_m}, 32'd0);

    for (int i = 0; i < n_vec; i++) begin
      apply(tbl[i]);
    end

    // One queued result while the pipeline never lets go of the port.
    apply(mk(0, 1, 0, 0, 5'd1, 5'd0, 32'h1, 1, 5'd17, 32'h17, 0, 1, 1, 5'd1, 32'h1, 0));
    for (int c = 2; c <= 5; c++) begin
      apply(mk(0, 1, 0, 0, 5'(c), 5'd0, 32'(c), 0, 5'd0, 32'h0, 0, 1, 1, 5'(c), 32'(c), 0));
    end
`ifdef WB_AGE_GUARD_EN
    apply(mk(0, 1, 0, 0, 5'd6, 5'd0, 32'h6, 0, 5'd0, 32'h0, 1, 1, 1, 5'd17, 32'h17, 1));
    apply(mk(0, 1, 0, 0, 5'd6, 5'd0, 32'h6, 0, 5'd0, 32'h0, 0, 1, 1, 5'd6,  32'h6,  0));
    apply(mk(0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 0, 5'd6,  32'h6,  0));
`else
    apply(mk(0, 1, 0, 0, 5'd6, 5'd0, 32'h6, 0, 5'd0, 32'h0, 0, 1, 1, 5'd6,  32'h6,  0));
    apply(mk(0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 1, 5'd17, 32'h17, 1));
    apply(mk(0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 0, 5'd17, 32'h17, 0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
